// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM
// state encoding and the nibble counter width helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-nibble operand still needs a one-bit counter.
    function automatic int cntWidth(input int numNibbles);
        return (numNibbles <= 1) ? 1 : $clog2(numNibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes of the nibble-serial adder. The master
// side is the producer/consumer; the slave side is the adder itself.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/rca_behavioural.sv
// Behavioural 4-bit ripple-carry adder. Purely combinational; the
// caller registers its inputs and outputs.
module rca_behavioural (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    assign o_sum  = w_full[3:0];
    assign o_cout = w_full[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that sequences WIDTH-bit operands through a single
// 4-bit adder, LSB nibble first, carrying between nibbles in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / NIBBLE_W;
    localparam int CW = cntWidth(N);

    state_t              r_state;
    state_t              w_nextState;
    logic [WIDTH-1:0]    r_aShift;
    logic [WIDTH-1:0]    r_bShift;
    logic [WIDTH-1:0]    r_sumShift;
    logic [WIDTH+3:0]    w_sumConcat;
    logic                r_carry;
    logic [CW-1:0]       r_cnt;
    logic                r_cout;
    logic                r_overflow;
    logic                r_outValid;
    logic [NIBBLE_W-1:0] w_addSum;
    logic                w_addCout;
    logic                w_inReady;
    logic                w_accept;
    logic                w_lastNibble;

    rca_behavioural u_rca (
        .i_a    (r_aShift[NIBBLE_W-1:0]),
        .i_b    (r_bShift[NIBBLE_W-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_addSum),
        .o_cout (w_addCout)
    );

    assign w_inReady    = (r_state == IDLE) && rst_n;
    assign w_accept     = bus.in_valid && w_inReady;
    assign w_lastNibble = (r_cnt == CW'(N - 1));
    // New nibble enters at the top while the register shifts right by one nibble.
    assign w_sumConcat  = {w_addSum, r_sumShift};

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.sum       = r_sumShift;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_overflow;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: accept, walk N nibbles, then wait for the consumer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_nextState = RUN;
            RUN:     if (w_lastNibble)  w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = IDLE;
            default:                    w_nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, per-nibble add/shift, and result holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aShift   <= '0;
            r_bShift   <= '0;
            r_sumShift <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_aShift <= bus.a;
                        r_bShift <= bus.b;
                        r_carry  <= bus.cin;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_sumShift <= w_sumConcat[WIDTH+3:NIBBLE_W];
                    r_aShift   <= r_aShift >> NIBBLE_W;
                    r_bShift   <= r_bShift >> NIBBLE_W;
                    r_carry    <= w_addCout;
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_lastNibble) begin
                        r_cout     <= w_addCout;
                        r_overflow <= (r_aShift[NIBBLE_W-1] == r_bShift[NIBBLE_W-1]) &&
                                      (w_addSum[NIBBLE_W-1] != r_aShift[NIBBLE_W-1]);
                        r_outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

    logic clk;
    logic rst_n;
    int   assertions;
    int   failures;
    int   cycle;
    int   lat;
    int   e0;
    int   e1;
    logic seenValid;

    nibble_serial_adder_if #(.WIDTH(16)) bus ();

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the next edge accepts the presented operands.
    task automatic waitAccept(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready && bus.in_valid) begin
                tick();
                return;
            end
            tick();
        end
        chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    // Count edges from accept until out_valid rises (bounded).
    task automatic waitOutValid(input string tag, output int latency);
        latency = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) return;
            tick();
            latency++;
        end
        chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    // Present one operand set, wait for the accept edge, then withdraw it.
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        waitAccept(tag);
        bus.in_valid = 1'b0;
        bus.a        = 16'hA5A5;
        bus.b        = 16'h5A5A;
        bus.cin      = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expSum, input logic expCout, input logic expOv);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"},   32'(bus.sum),       32'(expSum));
        chk({tag, "_cout"},  32'(bus.cout),      32'(expCout));
        chk({tag, "_ovf"},   32'(bus.overflow),  32'(expOv));
    endtask

    initial begin
        assertions    = 0;
        failures      = 0;
        cycle         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.overflow),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic add with latency measurement
        applyStimulus("basic", 16'h1234, 16'h4321, 1'b0);
        chk("basic_in_ready_run", 32'(bus.in_ready), 32'd0);
        waitOutValid("basic", lat);
        chk("basic_latency", 32'(lat), 32'd4);
        checkOutput("basic", 16'h5555, 1'b0, 1'b0);
        tick();
        chk("basic_handshake_valid", 32'(bus.out_valid), 32'd0);
        chk("basic_idle_in_ready",   32'(bus.in_ready),  32'd1);

        // Full-length carry ripple
        applyStimulus("ripple", 16'hFFFF, 16'h0000, 1'b1);
        waitOutValid("ripple", lat);
        chk("ripple_latency", 32'(lat), 32'd4);
        checkOutput("ripple", 16'h0000, 1'b1, 1'b0);
        tick();

        // Positive overflow
        applyStimulus("posovf", 16'h7FFF, 16'h0001, 1'b0);
        waitOutValid("posovf", lat);
        checkOutput("posovf", 16'h8000, 1'b0, 1'b1);
        tick();

        // Backpressure in DONE
        bus.out_ready = 1'b0;
        applyStimulus("bp", 16'h9ABC, 16'hA987, 1'b0);
        waitOutValid("bp", lat);
        checkOutput("bp", 16'h4443, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold", 16'h4443, 1'b1, 1'b1);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid",    32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready),  32'd1);

        // Reset during RUN after nibble 1
        applyStimulus("abort", 16'h1234, 16'h1111, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_sum",       32'(bus.sum),       32'd0);
        chk("abort_cout",      32'(bus.cout),      32'd0);
        chk("abort_ovf",       32'(bus.overflow),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready_high", 32'(bus.in_ready), 32'd1);
        seenValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seenValid = 1'b1;
        end
        chk("abort_no_valid", 32'(seenValid), 32'd0);

        // Negative overflow after the aborted operation
        applyStimulus("negovf", 16'h8000, 16'h8000, 1'b0);
        waitOutValid("negovf", lat);
        chk("negovf_latency", 32'(lat), 32'd4);
        checkOutput("negovf", 16'h0000, 1'b1, 1'b1);
        tick();

        // Back-to-back with in_valid held high and operands changed mid-RUN
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        waitAccept("b2b1");
        e0 = cycle;
        bus.a = 16'h0FFF;
        bus.b = 16'h0001;
        waitOutValid("b2b1", lat);
        checkOutput("b2b1", 16'h3333, 1'b0, 1'b0);
        waitAccept("b2b2");
        e1 = cycle;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b0;
        chk("b2b_spacing", 32'(e1 - e0), 32'd6);
        waitOutValid("b2b2", lat);
        checkOutput("b2b2", 16'h1000, 1'b0, 1'b0);
        tick();
        chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
